// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Signal bundle between the multi-cycle control FSM and its datapath.
//
//   Datapath -> control : instr, zero, mem_ready
//   Control -> datapath : PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//                         ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, RegWrite,
//                         retire, illegal, state
//
//   Modports:
//     master - the control FSM (drives the selects/enables)
//     slave  - the datapath side (drives IR contents and status)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUctrl;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic        retire;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  instr, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUctrl, ImmSrc, RegWrite, retire, illegal, state
  );

  modport slave (
    output instr, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUctrl, ImmSrc, RegWrite, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle control FSM for the RV32I-subset datapath. Sequences
//   fetch, decode, address/execute, memory and writeback so that a single
//   ALU and one unified memory port are shared across phases.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - multicycle_control_if.master: IR contents, ALU zero flag,
//            memory ready in; mux selects, enables, ALU control, retire /
//            illegal pulses and debug state out.
//
// Parameters:
//   BRANCH_NE - 1: funct3=001 under the branch opcode decodes as bne;
//               0: that encoding is illegal.
//
// Build option:
//   MEM_WAIT_EN - when defined, FETCH, MEMREAD and MEMWRITE stall while
//                 mem_ready is low; otherwise mem_ready is ignored.
//
// Outputs are combinational from state, instr and zero. The write strobes
// are additionally qualified by rst_n so that a reset that lands in the
// middle of an instruction cannot leak a PC, register or memory write.
// ---------------------------------------------------------------------------
module multicycle_control #(
  parameter bit BRANCH_NE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ---------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------

  // funct3 values the ALU decoder understands for R/I arithmetic.
  function automatic logic funct_legal(input logic [2:0] f3);
    logic v;
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: v = 1'b1;
      default:                        v = 1'b0;
    endcase
    return v;
  endfunction

  // ALU operation for EXECR/EXECI. Subtract only for R-type with instr[30].
  function automatic logic [2:0] funct_alu(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic       b30);
    logic [2:0] a;
    case (f3)
      3'b000:  a = (op[5] & b30) ? ALU_SUB : ALU_ADD;
      3'b010:  a = ALU_SLT;
      3'b110:  a = ALU_OR;
      3'b111:  a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Branch encodings we can resolve from the zero flag alone.
  function automatic logic branch_legal(input logic [2:0] f3);
    return (f3 == 3'b000) | ((f3 == 3'b001) & BRANCH_NE);
  endfunction

  // Immediate format follows the opcode, independent of state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    logic [1:0] s;
    case (op)
      OP_STORE:  s = 2'b01;
      OP_BRANCH: s = 2'b10;
      OP_JAL:    s = 2'b11;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

  // Whole-instruction legality as judged in DECODE.
  function automatic logic instr_legal(input logic [6:0] op,
                                       input logic [2:0] f3);
    logic v;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: v = 1'b1;
      OP_ALU_R, OP_ALU_I:        v = funct_legal(f3);
      OP_BRANCH:                 v = branch_legal(f3);
      default:                   v = 1'b0;
    endcase
    return v;
  endfunction

  // First execution state after DECODE for a legal instruction.
  function automatic state_t decode_target(input logic [6:0] op);
    state_t s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEMADR;
      OP_ALU_R:          s = S_EXECR;
      OP_ALU_I:          s = S_EXECI;
      OP_BRANCH:         s = S_BRANCH;
      OP_JAL:            s = S_JAL;
      default:           s = S_FETCH;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  state_t      r_state;
  state_t      w_next;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_b30;
  logic        w_mem_go;
  logic        w_taken;
  logic        w_unused;

  logic        w_pc_update;
  logic        w_branch;
  logic        w_adr_src;
  logic        w_mem_write;
  logic        w_ir_write;
  logic [1:0]  w_result_src;
  logic [1:0]  w_src_a;
  logic [1:0]  w_src_b;
  logic [2:0]  w_alu_ctrl;
  logic        w_reg_write;
  logic        w_retire;
  logic        w_illegal;

  assign w_op  = bus.instr[6:0];
  assign w_f3  = bus.instr[14:12];
  assign w_b30 = bus.instr[30];

`ifdef MEM_WAIT_EN
  // Memory phases complete only when the memory reports ready.
  assign w_mem_go = bus.mem_ready;
  assign w_unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
`else
  // Memory phases always complete in a single cycle.
  assign w_mem_go = 1'b1;
  assign w_unused = ^{bus.mem_ready, bus.instr[31], bus.instr[29:15],
                      bus.instr[11:7]};
`endif

  // Branch resolution: beq on zero, bne on not-zero. Illegal encodings
  // never reach BRANCH, so the fallback value is never used.
  assign w_taken = (w_f3 == 3'b000) ? bus.zero :
                   ((w_f3 == 3'b001) & BRANCH_NE) ? ~bus.zero : 1'b0;

  // State register: reset lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore/Mealy control decode.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_alu_ctrl   = ALU_ADD;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC.
        w_adr_src    = 1'b0;
        w_ir_write   = w_mem_go;
        w_pc_update  = w_mem_go;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_FOUR;
        w_alu_ctrl   = ALU_ADD;
        w_result_src = RES_ALURES;
        w_next       = w_mem_go ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm: branch/jal target parked in ALUOut.
        w_src_a    = SRCA_OLDPC;
        w_src_b    = SRCB_IMM;
        w_alu_ctrl = ALU_ADD;
        if (instr_legal(w_op, w_f3)) begin
          w_next = decode_target(w_op);
        end else begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end
      end
      S_MEMADR: begin
        w_src_a    = SRCA_RS1;
        w_src_b    = SRCB_IMM;
        w_alu_ctrl = ALU_ADD;
        w_next     = w_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_result_src = RES_ALUOUT;
        w_adr_src    = 1'b1;
        w_next       = w_mem_go ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe stays up across wait cycles; retire only on completion.
        w_result_src = RES_ALUOUT;
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_retire     = w_mem_go;
        w_next       = w_mem_go ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_src_a    = SRCA_RS1;
        w_src_b    = SRCB_RS2;
        w_alu_ctrl = funct_alu(w_op, w_f3, w_b30);
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a    = SRCA_RS1;
        w_src_b    = SRCB_IMM;
        w_alu_ctrl = funct_alu(w_op, w_f3, w_b30);
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_result_src = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1-rs2 while ALUOut (the target) feeds the PC.
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_RS2;
        w_alu_ctrl   = ALU_SUB;
        w_result_src = RES_ALUOUT;
        w_branch     = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_JAL: begin
        // PC <- target from DECODE; ALU forms OldPC+4 for rd in ALUWB.
        w_src_a      = SRCA_OLDPC;
        w_src_b      = SRCB_FOUR;
        w_alu_ctrl   = ALU_ADD;
        w_result_src = RES_ALUOUT;
        w_pc_update  = 1'b1;
        w_next       = S_ALUWB;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Output drive; write-type strobes are held off while reset is asserted.
  assign bus.PCWrite   = rst_n & (w_pc_update | (w_branch & w_taken));
  assign bus.AdrSrc    = w_adr_src;
  assign bus.MemWrite  = rst_n & w_mem_write;
  assign bus.IRWrite   = rst_n & w_ir_write;
  assign bus.ResultSrc = w_result_src;
  assign bus.ALUSrcA   = w_src_a;
  assign bus.ALUSrcB   = w_src_b;
  assign bus.ALUctrl   = w_alu_ctrl;
  assign bus.ImmSrc    = imm_sel(w_op);
  assign bus.RegWrite  = rst_n & w_reg_write;
  assign bus.retire    = rst_n & w_retire;
  assign bus.illegal   = rst_n & w_illegal;
  assign bus.state     = r_state;

endmodule
